// File: rtl/calc_pkg.sv
// Shared state encoding and operation-select codes for the calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_CAP_A   = 3'b001,
    S_WAIT_B  = 3'b010,
    S_CAP_B   = 3'b011,
    S_WAIT_OP = 3'b100,
    S_EXEC    = 3'b101,
    S_SHOW    = 3'b110,
    S_ERR     = 3'b111
  } state_t;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  // Exactly one operation switch must be on for a legal selection.
  function automatic logic op_legal(input logic add, input logic sub);
    return add ^ sub;
  endfunction

endpackage

// File: rtl/calc_sequencer_btn_sync_edge.sv
// Pushbutton conditioning: two-flop synchronizer plus an edge-detect flop.
// Produces a single-cycle press pulse per rising edge of the raw button.
module btn_sync_edge (
  input  logic clk,
  input  logic ar,
  input  logic btn_in,
  output logic press_out
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronize the raw button and keep one extra stage for edge detection.
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign press_out = r_s2 & ~r_s3;

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the sign-magnitude add/sub calculator: sequences A, B and
// operation entry from one ENTER button and drives load/select/display controls.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd50_000_000,
  parameter int unsigned CNT_W   = 26
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       enter,
  input  logic       sw_add,
  input  logic       sw_sub,
  output logic       a_load,
  output logic       b_load,
  output logic [1:0] op_sel,
  output logic       res_valid,
  output logic       blank_a,
  output logic       blank_b,
  output logic       blank_res,
  output logic       err,
  output logic [2:0] state_out
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             w_press;
  logic             w_timeout;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;

  btn_sync_edge u_enter_sync (
    .clk      (clk),
    .ar       (ar),
    .btn_in   (enter),
    .press_out(w_press)
  );

  // State, timeout counter and latched operation registers.
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state, timeout counting and Moore output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = '0;
    w_timeout   = (r_cnt == LP_CNT_LAST);
    a_load      = 1'b0;
    b_load      = 1'b0;
    op_sel      = OP_ZERO;
    res_valid   = 1'b0;
    blank_a     = 1'b1;
    blank_b     = 1'b1;
    blank_res   = 1'b1;
    err         = 1'b0;
    state_out   = r_state;

    case (r_state)
      S_IDLE: begin
        if (w_press) w_state_nxt = S_CAP_A;
      end
      S_CAP_A: begin
        a_load      = 1'b1;
        w_state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        blank_a = 1'b0;
        if (w_press)        w_state_nxt = S_CAP_B;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_CAP_B: begin
        b_load      = 1'b1;
        blank_a     = 1'b0;
        w_state_nxt = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        blank_a = 1'b0;
        blank_b = 1'b0;
        if (w_press) begin
          if (op_legal(sw_add, sw_sub)) begin
            w_state_nxt = S_EXEC;
            w_op_nxt    = sw_add ? OP_ADD : OP_SUB;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        blank_a     = 1'b0;
        blank_b     = 1'b0;
        op_sel      = r_op;
        w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        blank_a   = 1'b0;
        blank_b   = 1'b0;
        blank_res = 1'b0;
        res_valid = 1'b1;
        op_sel    = r_op;
        if (w_press) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        blank_a = 1'b0;
        blank_b = 1'b0;
        err     = 1'b1;
        if (w_press) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Counter only runs while waiting; any press or state change restarts it.
    if ((w_state_nxt == r_state) && !w_press &&
        ((r_state == S_WAIT_B) || (r_state == S_WAIT_OP))) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       ar = 1'b1;
  logic       enter = 1'b0;
  logic       sw_add = 1'b0;
  logic       sw_sub = 1'b0;
  logic       a_load, b_load, res_valid, blank_a, blank_b, blank_res, err;
  logic [1:0] op_sel;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  // Reference model: phase = spec state code, time spent in phase, latched op,
  // and the history of enter as sampled on the last three edges.
  int         m_phase;
  int         m_time;
  logic [1:0] m_op;
  logic       e1, e2, e3;

  calc_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .ar(ar), .enter(enter), .sw_add(sw_add), .sw_sub(sw_sub),
    .a_load(a_load), .b_load(b_load), .op_sel(op_sel), .res_valid(res_valid),
    .blank_a(blank_a), .blank_b(blank_b), .blank_res(blank_res), .err(err),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_time = 0; m_op = 2'b00; e1 = 0; e2 = 0; e3 = 0;
  endtask

  // Advance one clock; the model consumes the inputs held before the edge.
  task automatic tick();
    int  nxt;
    logic pr;
    if (ar) begin
      model_reset();
    end else begin
      pr  = e2 & ~e3;
      nxt = m_phase;
      case (m_phase)
        0: if (pr) nxt = 1;
        1: nxt = 2;
        2: if (pr) nxt = 3; else if (m_time + 1 == TO) nxt = 0;
        3: nxt = 4;
        4: if (pr) begin
             if (sw_add != sw_sub) begin nxt = 5; m_op = sw_add ? 2'b01 : 2'b10; end
             else nxt = 7;
           end else if (m_time + 1 == TO) nxt = 0;
        5: nxt = 6;
        default: if (pr) nxt = 0;
      endcase
      m_time  = (nxt != m_phase) ? 0 : m_time + 1;
      m_phase = nxt;
      e3 = e2; e2 = e1; e1 = enter;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_press();
    enter = 1'b1; tick();
    enter = 1'b0; tick();
    tick();
  endtask

  task automatic test_reset();
    int loads;
    ar = 1'b1; tick(); tick();
    if ({state_out, blank_a, blank_b, blank_res, op_sel, res_valid, err} !== 10'b000_111_00_0_0) begin
      errors++; $display("FAIL reset_outputs got %b want %b",
        {state_out, blank_a, blank_b, blank_res, op_sel, res_valid, err}, 10'b000_111_00_0_0);
    end
    checks++;
    ar = 1'b0;
    loads = 0;
    for (int i = 0; i < 5; i++) begin tick(); loads += int'(a_load) + int'(b_load); end
    if (loads != 0) begin errors++; $display("FAIL reset_no_load got %0d want 0", loads); end
    checks++;
  endtask

  task automatic test_add();
    sw_add = 1'b1; sw_sub = 1'b0;
    enter = 1'b1; tick();
    enter = 1'b0; tick();
    if ({state_out, a_load} !== 4'b000_0) begin
      errors++; $display("FAIL add_edge2 got %b want 0000", {state_out, a_load});
    end
    checks++;
    tick();
    if ({state_out, a_load} !== 4'b001_1) begin
      errors++; $display("FAIL add_a_load_edge3 got %b want 0011", {state_out, a_load});
    end
    checks++;
    tick();
    if ({state_out, a_load, blank_a, blank_b} !== 6'b010_0_0_1) begin
      errors++; $display("FAIL add_wait_b got %b want 010001", {state_out, a_load, blank_a, blank_b});
    end
    checks++;
    do_press();
    if ({state_out, b_load} !== 4'b011_1) begin
      errors++; $display("FAIL add_b_load got %b want 0111", {state_out, b_load});
    end
    checks++;
    tick();
    do_press();
    if ({state_out, op_sel, res_valid} !== 6'b101_01_0) begin
      errors++; $display("FAIL add_exec got %b want 101010", {state_out, op_sel, res_valid});
    end
    checks++;
    tick();
    if ({state_out, op_sel, res_valid, blank_res} !== 7'b110_01_1_0) begin
      errors++; $display("FAIL add_show got %b want 1100110", {state_out, op_sel, res_valid, blank_res});
    end
    checks++;
    do_press();
    if ({state_out, op_sel, res_valid, blank_res} !== 7'b000_00_0_1) begin
      errors++; $display("FAIL add_back_idle got %b want 0000001", {state_out, op_sel, res_valid, blank_res});
    end
    checks++;
  endtask

  task automatic test_sub();
    sw_add = 1'b0; sw_sub = 1'b1;
    do_press(); tick(); do_press(); tick(); do_press(); tick();
    if ({state_out, op_sel} !== 5'b110_10) begin
      errors++; $display("FAIL sub_show got %b want 11010", {state_out, op_sel});
    end
    checks++;
    sw_sub = 1'b0; sw_add = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    if ({state_out, op_sel} !== 5'b110_10) begin
      errors++; $display("FAIL sub_hold got %b want 11010", {state_out, op_sel});
    end
    checks++;
    do_press();
  endtask

  task automatic test_illegal();
    sw_add = 1'b1; sw_sub = 1'b1;
    do_press(); tick(); do_press(); tick(); do_press();
    if ({state_out, err, op_sel, blank_res} !== 7'b111_1_00_1) begin
      errors++; $display("FAIL illegal_err got %b want 1111001", {state_out, err, op_sel, blank_res});
    end
    checks++;
    do_press();
    if ({state_out, err} !== 4'b000_0) begin
      errors++; $display("FAIL illegal_clear got %b want 0000", {state_out, err});
    end
    checks++;
  endtask

  task automatic test_timeout();
    int stay;
    sw_add = 1'b1; sw_sub = 1'b0;
    do_press(); tick();
    stay = 0;
    for (int i = 0; i < TO - 1; i++) begin tick(); if (state_out == 3'b010) stay++; end
    if (stay != TO - 1) begin errors++; $display("FAIL timeout_early got %0d want %0d", stay, TO - 1); end
    checks++;
    tick();
    if (state_out !== 3'b000) begin errors++; $display("FAIL timeout_b got %b want 000", state_out); end
    checks++;
    do_press(); tick();
    for (int i = 0; i < 5; i++) tick();
    enter = 1'b1; tick();
    enter = 1'b0; tick();
    if (state_out !== 3'b010) begin errors++; $display("FAIL timeout_pre got %b want 010", state_out); end
    checks++;
    tick();
    if (state_out !== 3'b011) begin errors++; $display("FAIL timeout_press_wins got %b want 011", state_out); end
    checks++;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    if (state_out !== 3'b100) begin errors++; $display("FAIL timeout_op_early got %b want 100", state_out); end
    checks++;
    tick();
    if (state_out !== 3'b000) begin errors++; $display("FAIL timeout_op got %b want 000", state_out); end
    checks++;
  endtask

  task automatic test_held();
    int na, nb;
    na = 0; nb = 0;
    enter = 1'b1;
    for (int i = 0; i < 100; i++) begin tick(); na += int'(a_load); nb += int'(b_load); end
    enter = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); na += int'(a_load); nb += int'(b_load); end
    if (na != 1) begin errors++; $display("FAIL held_a_load got %0d want 1", na); end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL held_b_load got %0d want 0", nb); end
    checks++;
    if (state_out !== 3'b000) begin errors++; $display("FAIL held_state got %b want 000", state_out); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_press(); tick(); do_press(); tick();
    if (state_out !== 3'b100) begin errors++; $display("FAIL midrst_setup got %b want 100", state_out); end
    checks++;
    ar = 1'b1;
    #1;
    model_reset();
    if ({state_out, blank_a, blank_b, blank_res, op_sel} !== 8'b000_111_00) begin
      errors++; $display("FAIL midrst_async got %b want 00011100",
        {state_out, blank_a, blank_b, blank_res, op_sel});
    end
    checks++;
    tick(); tick();
    ar = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_load || b_load || !blank_a || !blank_b || !blank_res || state_out != 3'b000) bad++;
    end
    if (bad != 0) begin errors++; $display("FAIL midrst_quiet got %0d want 0", bad); end
    checks++;
  endtask

  task automatic test_random();
    int         hold;
    logic [10:0] exp, got;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        enter = ~enter;
        hold  = enter ? $urandom_range(1, 4) : $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 5) == 0) begin
        sw_add = $urandom_range(0, 1) == 1;
        sw_sub = $urandom_range(0, 1) == 1;
      end
      ar = ($urandom_range(0, 399) == 0);
      tick();
      ar = 1'b0;
      exp = {3'(m_phase), m_phase == 1, m_phase == 3,
             (m_phase == 5 || m_phase == 6) ? m_op : 2'b00, m_phase == 6,
             m_phase <= 1, m_phase <= 3, m_phase != 6, m_phase == 7};
      got = {state_out, a_load, b_load, op_sel, res_valid, blank_a, blank_b, blank_res, err};
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d got %b want %b", i, got, exp);
      end
      checks++;
    end
    enter = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_timeout();
    test_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
